// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 single-bit mux between four requesters.
// Define MUX4_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest) instead of round-robin.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic             done,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic [CNT_W-1:0] owner_cnt
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pick;
  logic             release_c;

`ifdef MUX4_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (req[k]) pick = 2'(k);
  end
`else
  // Scan from last+4 (== last, lowest priority) down to last+1 so the
  // nearest requester after the previous owner is assigned last and wins.
  always_comb begin
    logic [1:0] cand;
    cand = last_q;
    pick = last_q;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (req[cand]) pick = cand;
    end
  end
`endif

  assign release_c = done || !req[last_q] || (cnt_q == HOLD);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d  = 4'b0000;
        busy_d = 1'b0;
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          last_d  = pick;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        // sel intentionally keeps the old owner so the mux output doesn't glitch
        if (release_c) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != HOLD) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign owner_cnt = cnt_q;

endmodule
